// File: rtl/radio_sync_filt.sv
// Multi-channel synchroniser for asynchronous radio-control levels: per-channel
// flop chain, stability filter, registered edge pulses and saturating glitch counters.
module radio_sync_filt #(
  parameter int unsigned    NCH      = 2,
  parameter int unsigned    NSTAGES  = 2,
  parameter int unsigned    FILT_CYC = 3,
  parameter logic [NCH-1:0] RST_VAL  = '0,
  parameter int unsigned    GCW      = 8
) (
  input  logic               ck,
  input  logic               arst_n,
  input  logic [NCH-1:0]     async_in,
  input  logic [NCH-1:0]     byp,
  input  logic               gcnt_clr,
  output logic [NCH-1:0]     sync_out,
  output logic [NCH-1:0]     rise,
  output logic [NCH-1:0]     fall,
  output logic [NCH*GCW-1:0] gcnt
);

  localparam int unsigned    FCW     = $clog2(FILT_CYC + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FILT_CYC - 1);
  localparam logic [GCW-1:0] G_MAX   = '1;

  logic [NCH-1:0] r_chain [NSTAGES];
  logic [NCH-1:0] r_out;
  logic [NCH-1:0] r_rise;
  logic [NCH-1:0] r_fall;
  logic [FCW-1:0] r_fc    [NCH];
  logic [GCW-1:0] r_gcnt  [NCH];

  logic [NCH-1:0] w_s;
  logic [NCH-1:0] w_out_nxt;
  logic [NCH-1:0] w_glitch;
  logic [FCW-1:0] w_fc_nxt [NCH];

  assign w_s = r_chain[NSTAGES-1];

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned k = 0; k < NSTAGES; k++) r_chain[k] <= RST_VAL;
    end else begin
      r_chain[0] <= async_in;
      for (int unsigned k = 1; k < NSTAGES; k++) r_chain[k] <= r_chain[k-1];
    end
  end

  // A pending change that the synchronised level abandons before completing is a glitch.
  always_comb begin
    w_out_nxt = r_out;
    w_glitch  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_fc_nxt[i] = r_fc[i];
      if (byp[i]) begin
        w_out_nxt[i] = w_s[i];
        w_fc_nxt[i]  = '0;
      end else if (w_s[i] == r_out[i]) begin
        w_glitch[i]  = (r_fc[i] != '0);
        w_fc_nxt[i]  = '0;
      end else if (r_fc[i] == FC_LAST) begin
        w_out_nxt[i] = w_s[i];
        w_fc_nxt[i]  = '0;
      end else begin
        w_fc_nxt[i]  = r_fc[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      r_out  <= RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_fc[i]   <= '0;
        r_gcnt[i] <= '0;
      end
    end else begin
      r_out  <= w_out_nxt;
      r_rise <= w_out_nxt & ~r_out;
      r_fall <= ~w_out_nxt & r_out;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_fc[i] <= w_fc_nxt[i];
        if (gcnt_clr)
          r_gcnt[i] <= '0;
        else if (w_glitch[i] && (r_gcnt[i] != G_MAX))
          r_gcnt[i] <= r_gcnt[i] + 1'b1;
      end
    end
  end

  assign sync_out = r_out;
  assign rise     = r_rise;
  assign fall     = r_fall;

  always_comb begin
    gcnt = '0;
    for (int unsigned i = 0; i < NCH; i++) gcnt[i*GCW +: GCW] = r_gcnt[i];
  end

endmodule
